// File: rtl/regfile_mp_async_rst_n_pkg.sv
// Shared helpers and limits for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_LAT_COMB = 1'b0,
    RF_LAT_REG  = 1'b1
  } rf_read_lat_e;

  localparam int RF_MAX_PORTS = 8;

  function automatic int addr_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_async_rst_n_if.sv
// Read/write port bundle of the multi-port register file.
interface regfile_mp_async_rst_n_if #(
  parameter int WIDTH    = 32,
  parameter int N_REG    = 32,
  parameter int N_RPORTS = 2,
  parameter int N_WPORTS = 1
);
  localparam int AW = regfile_pkg::addr_w(N_REG);

  logic                               clr;
  logic [N_RPORTS-1:0][AW-1:0]        raddr;
  logic [N_RPORTS-1:0]                ren;
  logic [N_RPORTS-1:0][WIDTH-1:0]     rdata;
  logic [N_WPORTS-1:0][AW-1:0]        waddr;
  logic [N_WPORTS-1:0]                wen;
  logic [N_WPORTS-1:0][WIDTH-1:0]     wdata;
  logic                               wconflict;

  modport master (
    output clr, raddr, ren, waddr, wen, wdata,
    input  rdata, wconflict
  );

  modport slave (
    input  clr, raddr, ren, waddr, wen, wdata,
    output rdata, wconflict
  );

endinterface

// File: rtl/regfile_mp_async_rst_n_reg.sv
// One architectural register: async reset, sync clear, load enable.
module register_en_async_rst_n #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // clr outranks the load so a same-cycle write is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dout <= RESET_VAL;
    else if (clr) dout <= RESET_VAL;
    else if (en)  dout <= din;
  end

endmodule

// File: rtl/regfile_mp_async_rst_n.sv
// Multi-port register file, async active-low reset, optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp_async_rst_n
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_REG     = 32,
  parameter int               N_RPORTS  = 2,
  parameter int               N_WPORTS  = 1,
  parameter int               READ_LAT  = 0,
  parameter int               ZERO_REG  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_mp_async_rst_n_if.slave bus
);

  localparam int AW = addr_w(N_REG);

  if (N_REG < 2 || (READ_LAT != 0 && READ_LAT != 1) ||
      N_RPORTS < 1 || N_WPORTS < 1 ||
      N_RPORTS > RF_MAX_PORTS || N_WPORTS > RF_MAX_PORTS) begin : g_bad_cfg
    $error("regfile_mp_async_rst_n: illegal parameter combination");
  end

  logic [N_REG-1:0][WIDTH-1:0]    rf_q;
  logic [N_REG-1:0]               reg_dup;
  logic [N_RPORTS-1:0][WIDTH-1:0] rd_comb;
  logic [N_RPORTS-1:0][WIDTH-1:0] rd_out;
  logic                           wconf_q;

  // Per-register write select: later ports override, so the highest index wins.
  for (genvar r = 0; r < N_REG; r++) begin : g_reg
    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign rf_q[r]    = '0;
      assign reg_dup[r] = 1'b0;
    end else begin : g_live
      logic             we;
      logic             dup;
      logic [WIDTH-1:0] wd;

      always_comb begin
        we  = 1'b0;
        dup = 1'b0;
        wd  = '0;
        for (int p = 0; p < N_WPORTS; p++) begin
          if (bus.wen[p] && bus.waddr[p] == AW'(r)) begin
            dup = dup | we;
            we  = 1'b1;
            wd  = bus.wdata[p];
          end
        end
      end

      assign reg_dup[r] = dup;

      register_en_async_rst_n #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .en    (we),
        .din   (wd),
        .dout  (rf_q[r])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wconf_q <= 1'b0;
    else        wconf_q <= |reg_dup;
  end

  // Read mux by compare-and-select: addresses past N_REG match nothing and read 0.
  for (genvar j = 0; j < N_RPORTS; j++) begin : g_rd
    logic [WIDTH-1:0] val;
    logic             hit;

    always_comb begin
      val = '0;
      hit = 1'b0;
      for (int r = 0; r < N_REG; r++) begin
        if (bus.raddr[j] == AW'(r)) begin
          val = rf_q[r];
          hit = 1'b1;
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (hit && !(ZERO_REG != 0 && bus.raddr[j] == '0)) begin
        for (int p = 0; p < N_WPORTS; p++) begin
          if (bus.wen[p] && bus.waddr[p] == bus.raddr[j])
            val = bus.clr ? RESET_VAL : bus.wdata[p];
        end
      end
`endif
    end

    assign rd_comb[j] = val;
  end

  if (READ_LAT == int'(RF_LAT_REG)) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_out <= '0;
      else begin
        for (int j = 0; j < N_RPORTS; j++)
          if (bus.ren[j]) rd_out[j] <= rd_comb[j];
      end
    end
  end else begin : g_lat0
    logic unused_ren;
    assign unused_ren = ^bus.ren;
    assign rd_out     = rd_comb;
  end

  assign bus.rdata     = rd_out;
  assign bus.wconflict = wconf_q;

endmodule

// File: doc/regfile_mp_async_rst_n.md
Name: regfile_mp_async_rst_n

Overview:
Parametrised multi-port register file with asynchronous active-low reset. It generalises the single-port register file with:
- correct per-register write decode across N_WPORTS ports, with deterministic conflict priority;
- configurable read latency (combinational or registered);
- optional hardwired-zero register 0;
- synchronous bulk clear;
- out-of-range address protection for non-power-of-2 depth.

It sits in datapath and CSR clusters as the general architectural-state store.

Parameters:
WIDTH, 32, bits per register
N_REG, 32, number of registers (>=2, need not be a power of 2)
N_RPORTS, 2, number of read ports (>=1)
N_WPORTS, 1, number of write ports (>=1)
READ_LAT, 0, read latency in cycles, 0 or 1 only
ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes
RESET_VAL, '0, WIDTH-bit value loaded into every register on reset and on clear

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all registers to RESET_VAL
raddr  input  N_RPORTS x AW  read addresses, AW = max(1,$clog2(N_REG))
ren  input  N_RPORTS  read enable; used only when READ_LAT=1
rdata  output  N_RPORTS x WIDTH  read data
waddr  input  N_WPORTS x AW  write addresses
wen  input  N_WPORTS  write enables
wdata  input  N_WPORTS x WIDTH  write data
wconflict  output  1  registered flag: previous cycle had >=2 enabled writes to one address

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, async assert, sync release): all registers = RESET_VAL (register 0 = 0 when ZERO_REG=1); rdata pipeline regs = 0; wconflict = 0. Reset mid-operation discards in-flight writes and reads immediately.
- Write: on a rising edge, register r loads wdata[p] when wen[p]=1 and waddr[p]==r.
- Write conflicts: if several ports hit r, the highest port index wins. wconflict=1 on the following cycle, for exactly one cycle per conflicting cycle.
- Out-of-range writes (waddr >= N_REG): ignored, no state change.
- clr=1: every register <= RESET_VAL on the next edge. clr takes priority over all writes in the same cycle. wconflict is still computed.
- ZERO_REG=1: writes to address 0 are dropped, including for conflict detection; reads of address 0 return 0.
- Read, READ_LAT=0: rdata[j] = reg[raddr[j]] combinationally. Read-during-write returns the old value unless REGFILE_BYPASS_EN is set.
- Read, READ_LAT=1: when ren[j]=1, rdata[j] is registered at the edge and valid the next cycle; when ren[j]=0, rdata[j] holds its value. Sampling uses the pre-write register contents, unless REGFILE_BYPASS_EN is set.
- Out-of-range reads return 0.
- Widths: no arithmetic. Address comparisons are AW bits wide. N_REG=1 is illegal; a static assertion enforces this, plus READ_LAT in {0,1} and N_REG>=2.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled same-cycle write returns that write's wdata, using the highest matching port index.
  - READ_LAT=0: forwarding is combinational.
  - READ_LAT=1: the registered rdata captures the forwarded value.
  - clr in the same cycle forwards RESET_VAL instead.
  - Address 0 with ZERO_REG=1 never forwards.
- Undefined: no forwarding; a read always sees the pre-edge register contents.

Decomposition:
- Package regfile_pkg:
  - function addr_w(n) returning max(1,$clog2(n));
  - typedef rf_read_lat_e {RF_LAT_COMB=0, RF_LAT_REG=1};
  - localparam RF_MAX_PORTS=8 (the limit checked by the static assertion).
- Sub-module register_en_async_rst_n: WIDTH, RESET_VAL; ports clk, rst_n, clr, en, din, dout. Instantiated once per register; for register 0 it is replaced by a constant 0 when ZERO_REG=1.
- The write-select priority mux and conflict detector live in the top module as generate loops.

Test Plan:
1. Reset with RESET_VAL=32'hDEAD_BEEF, N_REG=8 -> after release, all 8 addresses read 32'hDEADBEEF; wconflict=0.
2. Single write, port0 waddr=3, wdata=32'h1234_5678 -> next cycle raddr[0]=3 returns 32'h12345678 (READ_LAT=0). With READ_LAT=1 and ren=1, the value appears one cycle later.
3. N_WPORTS=2, both write address 5, wdata 32'hA / 32'hB -> reg5=32'hB; wconflict=1 for exactly one cycle.
4. clr=1 together with a write of 32'h55 to address 2 -> reg2=RESET_VAL. ZERO_REG=1: write 32'hFF to address 0 -> reads 0.
5. N_REG=6: write address 7 with 32'h77 -> no register changes; read address 7 returns 0.
6. REGFILE_BYPASS_EN defined: same-cycle write 32'hC0DE to address 4 and read of address 4 -> rdata=32'hC0DE in the same cycle (LAT=0) or the next cycle (LAT=1). Macro undefined -> the old value is returned.
7. Reset asserted mid-stream while wen=1 -> registers show RESET_VAL immediately without waiting for a clock edge; the pending write is lost.
